load_store_controller: RTL

Sequences every core load/store through single-port data memory with a req/ack handshake. Aligns addresses to words and builds store byte enables with lane-replicated store data. For loads, latches the memory word and drives the Load_Block controls (Load_Memory, Load_Select, Offset), then returns the extracted Load_data to the core. Sits between the execute stage and data memory; one access in flight at a time.

---
 rtl/load_store_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_controller.sv
// load_store_controller
// ---------------------
// Sequences one core load or store at a time through a single-port data
// memory using a req/ack handshake. Addresses are word aligned for the
// memory. Stores get byte enables, and byte store data is replicated
// across all four lanes. For loads the returned word is latched and handed
// to an external Load_Block through Load_Memory, Load_Select and Offset.
// The extracted Load_data comes back from that block and is returned to the
// core on a one-cycle response pulse.
//
// Optional feature macro: LSC_TIMEOUT_EN
//   When defined, an access that sees no Mem_Ack for TIMEOUT_CYCLES cycles
//   is abandoned and answered with Bus_Error. When undefined, the controller
//   waits for Mem_Ack indefinitely and Bus_Error is tied low.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   Req_Valid/Req_Ready         core request handshake (ready only in IDLE)
//   Req_Write, Req_Byte         store/load select, byte/word size
//   Req_Addr, Req_Wdata         byte address, store data (byte in [7:0])
//   Mem_Req/Mem_Ack             memory request, one-cycle completion pulse
//   Mem_Addr, Mem_We            word-aligned address, write enable
//   Mem_Be, Mem_Wdata           byte enables, lane-replicated store data
//   Mem_Rdata                   read data, valid with Mem_Ack
//   Load_Memory, Load_Select,
//   Offset                      controls to the Load_Block
//   Load_data                   Load_Block result (combinational)
//   Resp_Valid, Resp_Data       one-cycle response pulse and load result
//   Misaligned, Bus_Error       error flags, valid with Resp_Valid

module load_store_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req_Valid,
    output logic                  Req_Ready,
    input  logic                  Req_Write,
    input  logic                  Req_Byte,
    input  logic [ADDR_WIDTH-1:0] Req_Addr,
    input  logic [31:0]           Req_Wdata,
    output logic                  Mem_Req,
    input  logic                  Mem_Ack,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic                  Mem_We,
    output logic [3:0]            Mem_Be,
    output logic [31:0]           Mem_Wdata,
    input  logic [31:0]           Mem_Rdata,
    output logic [31:0]           Load_Memory,
    output logic                  Load_Select,
    output logic [1:0]            Offset,
    input  logic [31:0]           Load_data,
    output logic                  Resp_Valid,
    output logic [31:0]           Resp_Data,
    output logic                  Misaligned,
    output logic                  Bus_Error
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        EXTRACT,
        RESP,
        ERR
    } state_t;

    state_t state;

`ifdef LSC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_count;
`else
    // The timeout length only matters when the timeout logic is built in.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign Bus_Error          = 1'b0;
`endif

    // Single FSM; every output is a register updated on state transitions so
    // the memory-side signals stay stable for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            Req_Ready   <= 1'b1;
            Mem_Req     <= 1'b0;
            Mem_Addr    <= '0;
            Mem_We      <= 1'b0;
            Mem_Be      <= 4'b0000;
            Mem_Wdata   <= 32'd0;
            Load_Memory <= 32'd0;
            Load_Select <= 1'b0;
            Offset      <= 2'b00;
            Resp_Valid  <= 1'b0;
            Resp_Data   <= 32'd0;
            Misaligned  <= 1'b0;
`ifdef LSC_TIMEOUT_EN
            Bus_Error   <= 1'b0;
            wait_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Req_Valid) begin
                        Req_Ready <= 1'b0;
                        if (!Req_Byte && (Req_Addr[1:0] != 2'b00)) begin
                            // Unaligned word access never reaches memory.
                            state      <= ERR;
                            Resp_Valid <= 1'b1;
                            Misaligned <= 1'b1;
                            Resp_Data  <= 32'd0;
                        end else begin
                            state       <= ACCESS;
                            Mem_Req     <= 1'b1;
                            Mem_Addr    <= {Req_Addr[ADDR_WIDTH-1:2], 2'b00};
                            Mem_We      <= Req_Write;
                            Offset      <= Req_Addr[1:0];
                            Load_Select <= Req_Byte;
                            if (Req_Byte) begin
                                Mem_Be    <= 4'b0001 << Req_Addr[1:0];
                                Mem_Wdata <= {4{Req_Wdata[7:0]}};
                            end else begin
                                Mem_Be    <= 4'b1111;
                                Mem_Wdata <= Req_Wdata;
                            end
`ifdef LSC_TIMEOUT_EN
                            wait_count <= '0;
`endif
                        end
                    end
                end

                ACCESS: begin
                    // Mem_Ack takes priority over a timeout in the same cycle.
                    if (Mem_Ack) begin
                        Mem_Req <= 1'b0;
                        if (Mem_We) begin
                            state      <= RESP;
                            Resp_Valid <= 1'b1;
                            Resp_Data  <= 32'd0;
                        end else begin
                            state       <= EXTRACT;
                            Load_Memory <= Mem_Rdata;
                        end
                    end
`ifdef LSC_TIMEOUT_EN
                    else if (wait_count == CW'(TIMEOUT_CYCLES - 1)) begin
                        Mem_Req    <= 1'b0;
                        state      <= ERR;
                        Resp_Valid <= 1'b1;
                        Bus_Error  <= 1'b1;
                        Resp_Data  <= 32'd0;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
`endif
                end

                EXTRACT: begin
                    // Load_Block has had a full cycle to settle on the latched word.
                    Resp_Data  <= Load_data;
                    Resp_Valid <= 1'b1;
                    state      <= RESP;
                end

                RESP, ERR: begin
                    Resp_Valid <= 1'b0;
                    Misaligned <= 1'b0;
`ifdef LSC_TIMEOUT_EN
                    Bus_Error  <= 1'b0;
`endif
                    Req_Ready  <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
